ap_ctrl_stream_task: RTL and testbench
======================================

# ap_ctrl_stream_task

Child-side responder for the ap_ctrl_hs start/ready/done/idle handshake issued by the top-level task control FSM. On an accepted `ap_start` it latches its scalar arguments and emits `n` 64-bit words (`base`, `base+1`, …) into a downstream FIFO write port. It then reports completion with `ap_done`. It sits between the per-task control FSM and a stream FIFO, as a stream-source task instance.

## Interface
Parameters:
- none; all widths fixed at 64 bits to match the control FSM scalar ports.

Ports:
- `ap_clk` in 1: sole clock, rising edge.
- `ap_rst_n` in 1: reset, asynchronous, active-low.
- `ap_start` in 1: start request, held high by initiator until `ap_ready`.
- `ap_ready` out 1: arguments accepted this cycle.
- `ap_done` out 1: task finished.
- `ap_idle` out 1: no task in progress.
- `n` in 64: beat count, sampled on acceptance.
- `base` in 64: first data value, sampled on acceptance.
- `dout` out 64: stream data.
- `dout_write` out 1: write strobe to FIFO.
- `dout_full_n` in 1: FIFO not full.
- `ap_continue` in 1: present only with `AP_CTRL_STREAM_TASK_CONTINUE_EN`.

## Operation
- Registers:
  - `state` with values IDLE, RUN, DONE.
  - `n_q[63:0]`, `base_q[63:0]`, `idx[63:0]`.
- IDLE:
  - `ap_ready = ap_start`.
  - On `ap_start`: latch `n_q<=n`, `base_q<=base`, `idx<=0`.
  - If `n==0`, go to DONE; otherwise go to RUN.
  - Without `ap_start`, stay in IDLE.
- RUN:
  - `dout_write = dout_full_n`; `dout = base_q + idx`, modulo 2^64 (wraps silently).
  - On each write, `idx<=idx+1`.
  - On a write with `idx == n_q-1`, go to DONE.
  - `ap_start` is ignored and `ap_ready` is 0.
- DONE:
  - `ap_done=1`.
  - Without the macro, return to IDLE the next cycle (one-cycle `ap_done` pulse).
- `ap_idle = (state==IDLE)`.
- `ap_ready` is 0 outside IDLE and while `ap_rst_n` is low.
- `dout_write` is 0 outside RUN.
- `n_q`, `base_q` and `idx` hold their values outside the acceptance and write cycles.
- Input changes on `n` and `base` after acceptance have no effect.
- Initiator compatibility:
  - `ap_ready` without `ap_done` in the same cycle moves the initiator to its wait-for-done state.
  - The later `ap_done` pulse completes the handshake.
  - `ap_ready` and `ap_done` are never asserted in the same cycle.
- Reset (asynchronous, any state, including mid-RUN):
  - `state` goes to IDLE; `n_q`, `base_q` and `idx` clear to 0.
  - Partial output is abandoned; no `ap_done` is issued.
- Reset values of outputs: `ap_idle=1`, `ap_ready=0`, `ap_done=0`, `dout_write=0`, `dout=0`.

## Timing
Cycle 0 is the acceptance cycle (`ap_start=1` in IDLE).
- Cycle 0: `ap_ready=1` combinationally.
- Cycle 1: `ap_idle=0`.
- With `dout_full_n` held at 1:
  - Writes occur in cycles 1..n.
  - `ap_done=1` in cycle n+1.
  - `ap_idle=1` from cycle n+2.
- Each cycle with `dout_full_n=0` in RUN stalls completion by one cycle; `dout` holds its value.
- `n==0`: no writes; `ap_done` in cycle 1; idle in cycle 2.
- `ap_start` held high continuously: a new acceptance occurs in the first IDLE cycle after DONE, so back-to-back tasks are spaced by one IDLE cycle.
- There is no combinational path from `dout_full_n` to anything except `dout_write`.

## Configuration
- `AP_CTRL_STREAM_TASK_CONTINUE_EN` defined:
  - Adds the `ap_continue` input.
  - DONE holds `ap_done=1` until a cycle with `ap_continue=1`, then goes to IDLE the next cycle.
  - `ap_continue` in IDLE or RUN is ignored.
- Undefined: no `ap_continue` port; DONE lasts exactly one cycle.

## Test plan
- Basic run: reset, then `n=4`, `base=100`, `ap_start` held until `ap_ready`, `full_n=1`.
  - `ap_ready` in cycle 0; `dout` 100,101,102,103 in cycles 1-4.
  - `ap_done` in cycle 5 only; `ap_idle` in cycle 6.
- Zero length: `n=0`.
  - `ap_ready` in cycle 0, no `dout_write`, `ap_done` in cycle 1.
  - `ap_ready` and `ap_done` never coincide.
- Backpressure: `n=3`, `base=0`, `full_n` low in cycles 2-3.
  - Writes of 0, 1, 2 occur in cycles 1, 4, 5; `ap_done` in cycle 6.
- Wrap-around: `base=0xFFFF_FFFF_FFFF_FFFE`, `n=3`.
  - `dout` sequence `…FFFE`, `…FFFF`, `0x0`.
- Reset mid-run: `n=10`, assert `ap_rst_n=0` after 3 writes.
  - Immediately `dout_write=0` and `ap_idle=1`; no `ap_done`.
  - A new start with `n=2`, `base=7` yields 7, 8, then `ap_done`.
- Continue (macro defined): `n=1` with `ap_continue` low for 3 cycles after done.
  - `ap_done` stays high 4 cycles and drops after `ap_continue`.
  - A new `ap_start` is not accepted until IDLE.

Source files
------------

// File: rtl/ap_ctrl_stream_task.sv
// ap_ctrl_stream_task
// Child-side responder for the ap_ctrl_hs start/ready/done/idle handshake.
// On an accepted ap_start it latches n and base, then writes n 64-bit words
// base, base+1, ... (modulo 2^64) into a downstream FIFO write port, and
// finally reports completion with ap_done.
//
// Optional feature: define AP_CTRL_STREAM_TASK_CONTINUE_EN to add the
// ap_continue input; ap_done is then held until ap_continue is seen.
// Without the macro, ap_done is a single-cycle pulse.

module ap_ctrl_stream_task (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_ready,
  output logic        ap_done,
  output logic        ap_idle,
  input  logic [63:0] n,
  input  logic [63:0] base,
  output logic [63:0] dout,
  output logic        dout_write,
`ifdef AP_CTRL_STREAM_TASK_CONTINUE_EN
  input  logic        dout_full_n,
  input  logic        ap_continue
`else
  input  logic        dout_full_n
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [63:0] n_q;
  logic [63:0] base_q;
  logic [63:0] idx_q;

  logic        in_idle;
  logic        in_run;
  logic        last_beat;
  logic        leave_done;

  // Decode the current state once; every output is a function of it.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    in_idle    = 1'b0;
    in_run     = 1'b0;
    last_beat  = 1'b0;
    leave_done = 1'b0;
    case (state_q)
      IDLE: in_idle = 1'b1;
      RUN: begin
        in_run    = 1'b1;
        last_beat = (idx_q == n_q - 64'd1);
      end
      DONE: begin
`ifdef AP_CTRL_STREAM_TASK_CONTINUE_EN
        leave_done = ap_continue;
`else
        leave_done = 1'b1;
`endif
      end
      default: leave_done = 1'b1;
    endcase
  end

  // ap_ready is the only combinational handshake output; gating with
  // ap_rst_n keeps it low while reset is asserted even though state is IDLE.
  assign ap_ready   = ap_rst_n & ap_start & in_idle;
  assign ap_idle    = in_idle;
  assign ap_done    = (state_q == DONE);
  // dout_full_n reaches only the write strobe; stalls simply hold idx_q.
  assign dout_write = in_run & dout_full_n;
  // Sum wraps silently at 64 bits.
  assign dout       = base_q + idx_q;

  // Control FSM plus argument and beat-index registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the async reset clears all state, which
    // abandons any partial stream without ever raising ap_done.
    if (!ap_rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            n_q    <= n;
            base_q <= base;
            idx_q  <= '0;
            state_q <= (n == 64'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (dout_full_n) begin
            idx_q <= idx_q + 64'd1;
            if (last_beat) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (leave_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_ctrl_stream_task.sv
// Testbench for ap_ctrl_stream_task.
// Stimulus pushes the expected write beats and done cycles into a scoreboard
// queue at acceptance time; a monitor on the falling edge pops an entry for
// every output event and compares kind, cycle and data.

module tb_ap_ctrl_stream_task;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;
  logic [63:0] n;
  logic [63:0] base;
  logic [63:0] dout;
  logic        dout_write;
  logic        dout_full_n;
  logic        ap_continue;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [63:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  ap_ctrl_stream_task dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .n           (n),
    .base        (base),
    .dout        (dout),
    .dout_write  (dout_write),
`ifdef AP_CTRL_STREAM_TASK_CONTINUE_EN
    .dout_full_n (dout_full_n),
    .ap_continue (ap_continue)
`else
    .dout_full_n (dout_full_n)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: handshake exclusivity every cycle, and scoreboard pop per event.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      check("ready_done_excl", {63'b0, ap_ready & ap_done}, 64'd0);
      if (dout_write || ap_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {62'b0, ap_done, dout_write}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("ev_kind", {63'b0, ap_done}, {63'b0, mon_e.is_done});
          check("ev_cycle", 64'(cyc), 64'(mon_e.cyc));
          if (!mon_e.is_done) check("wr_data", dout, mon_e.data);
        end
      end
    end
  end

  // One task: start, queue expectations, drive full_n/continue per cycle.
  // Stall window [st_lo, st_hi] is in cycles relative to acceptance.
  task automatic run_task(input logic [63:0] nn, input logic [63:0] bb,
                          input int st_lo, input int st_hi, input int cont_wait,
                          input bit hold, output int t0, output int t_idle);
    int  k;
    int  done_k;
    int  wr;
    ev_t e;
    n           = nn;
    base        = bb;
    ap_start    = 1'b1;
    dout_full_n = 1'b1;
    ap_continue = (cont_wait == 0);
    #1;
    for (int i = 0; i < 20 && !ap_ready; i++) @(negedge ap_clk);
    check("accept_ready", {63'b0, ap_ready}, 64'd1);
    t0 = cyc;
    k = 1;
    for (int i = 0; i < int'(nn); i++) begin
      while (k >= st_lo && k <= st_hi) k++;
      e = '{1'b0, t0 + k, bb + 64'(i)};
      exp_q.push_back(e);
      k++;
    end
    done_k = k;
    for (int j = 0; j <= cont_wait; j++) begin
      e = '{1'b1, t0 + done_k + j, 64'd0};
      exp_q.push_back(e);
    end
    @(posedge ap_clk);
    #1;
    ap_start = hold;
    n        = 64'hDEAD_BEEF_0000_0001;
    base     = 64'h0000_0000_0000_1234;
    wr = 0;
    for (int c = 1; c <= done_k + cont_wait + 1; c++) begin
      if (c > 1) begin
        @(posedge ap_clk);
        #1;
      end
      dout_full_n = !(c >= st_lo && c <= st_hi);
      ap_continue = (c >= done_k + cont_wait);
      @(negedge ap_clk);
      if (c == 1) check("busy_cycle1", {63'b0, ap_idle}, 64'd0);
      if (c < done_k && !dout_full_n) begin
        check("stall_nowrite", {63'b0, dout_write}, 64'd0);
        check("stall_hold", dout, bb + 64'(wr));
      end
      if (c < done_k && dout_full_n) wr++;
      if (c == done_k + cont_wait + 1) check("idle_after_done", {63'b0, ap_idle}, 64'd1);
    end
    t_idle = t0 + done_k + cont_wait + 1;
    dout_full_n = 1'b1;
  endtask

  initial begin
    int t0, t_idle, t0b, t_idle_b;
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t_idle, t0b, t_idle_b;
    ev_t e;
    ap_rst_n    = 1'b0;
    ap_start    = 1'b1;
    n           = 64'd5;
    base        = 64'd9;
    dout_full_n = 1'b1;
    ap_continue = 1'b1;
    repeat (2) @(negedge ap_clk);
    // Reset state, with ap_start high to show ap_ready is gated by reset.
    check("rst_idle",  {63'b0, ap_idle},    64'd1);
    check("rst_ready", {63'b0, ap_ready},   64'd0);
    check("rst_done",  {63'b0, ap_done},    64'd0);
    check("rst_write", {63'b0, dout_write}, 64'd0);
    check("rst_dout",  dout,                64'd0);
    ap_start = 1'b0;
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Basic run: 100..103 in cycles 1-4, done in 5, idle in 6.
    run_task(64'd4, 64'd100, 0, -1, 0, 1'b0, t0, t_idle);
    // Zero length: done in cycle 1, idle in 2.
    run_task(64'd0, 64'd55, 0, -1, 0, 1'b0, t0, t_idle);
    // Backpressure: full_n low in cycles 2-3; writes in 1,4,5; done in 6.
    run_task(64'd3, 64'd0, 2, 3, 0, 1'b0, t0, t_idle);
    // Wrap-around past 2^64.
    run_task(64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0, -1, 0, 1'b0, t0, t_idle);

    // Back-to-back with ap_start held: re-acceptance in the first IDLE cycle.
    run_task(64'd2, 64'd10, 0, -1, 0, 1'b1, t0, t_idle);
    run_task(64'd1, 64'd20, 0, -1, 0, 1'b0, t0b, t_idle_b);
    check("b2b_accept_cycle", 64'(t0b), 64'(t_idle));

    // Reset mid-run after three writes.
    n        = 64'd10;
    base     = 64'd500;
    ap_start = 1'b1;
    #1;
    for (int i = 0; i < 20 && !ap_ready; i++) @(negedge ap_clk);
    check("mid_accept_ready", {63'b0, ap_ready}, 64'd1);
    t0 = cyc;
    for (int i = 1; i <= 3; i++) begin
      e = '{1'b0, t0 + i, 64'd500 + 64'(i - 1)};
      exp_q.push_back(e);
    end
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_write", {63'b0, dout_write}, 64'd0);
    check("midrst_idle",  {63'b0, ap_idle},    64'd1);
    check("midrst_done",  {63'b0, ap_done},    64'd0);
    check("midrst_dout",  dout,                64'd0);
    repeat (2) @(negedge ap_clk);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("midrst_scoreboard_drained", 64'(exp_q.size()), 64'd0);
    run_task(64'd2, 64'd7, 0, -1, 0, 1'b0, t0, t_idle);

`ifdef AP_CTRL_STREAM_TASK_CONTINUE_EN
    // Continue: done held four cycles; ap_start held but not accepted until IDLE.
    run_task(64'd1, 64'd42, 0, -1, 3, 1'b1, t0, t_idle);
    run_task(64'd1, 64'd43, 0, -1, 0, 1'b0, t0b, t_idle_b);
    check("cont_accept_cycle", 64'(t0b), 64'(t_idle));
`endif

    repeat (3) @(negedge ap_clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
